// File: rtl/sram_pkg.sv
// Shared types and constants for the 512Kx8 asynchronous SRAM initiator.
// Timing constants are in clock cycles; every phase is timed by one 4-bit down-counter.
package sram_pkg;

   localparam int ADDR_W       = 19;
   localparam int DATA_W       = 8;
   localparam int CNT_W        = 4;

   localparam int SETUP_DEF    = 1;
   localparam int RD_WAIT_DEF  = 2;
   localparam int WR_PULSE_DEF = 2;
   localparam int HOLD_DEF     = 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_READ    = 3'd2,
      ST_WRITE   = 3'd3,
      ST_HOLD    = 3'd4,
      ST_RECOVER = 3'd5
   } state_e;

   // The counter counts down to zero, so a phase of N cycles loads N-1.
   function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/sram_if_m.sv
// Single-beat valid/ready host port to asynchronous SRAM strobe sequencer.
// Every ram_* output is a flop loaded from the next-state decode, so strobes cannot glitch.
module sram_if_m
   import sram_pkg::*;
#(
   parameter int SETUP    = SETUP_DEF,
   parameter int RD_WAIT  = RD_WAIT_DEF,
   parameter int WR_PULSE = WR_PULSE_DEF,
   parameter int HOLD     = HOLD_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rnw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_ceb,
   output logic              ram_rnw,
   output logic              ram_oeb,
   output logic [DATA_W-1:0] ram_data_o,
   output logic              ram_data_oe,
   input  logic [DATA_W-1:0] ram_data_i,
   output state_e            dbg_state
);

   if (SETUP < 1 || SETUP > 15 || RD_WAIT < 1 || RD_WAIT > 15 ||
       WR_PULSE < 1 || WR_PULSE > 15 || HOLD < 1 || HOLD > 15) begin : g_bad_param
      $error("sram_if_m: timing parameters must lie in 1..15");
   end

   state_e            r_state;
   state_e            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              r_rnw_op;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_req_ready;
   logic              r_rsp_valid;
   logic              r_ceb;
   logic              r_rnw;
   logic              r_oeb;
   logic              r_data_oe;

   logic              w_accept;
   logic              w_last;
   logic              w_op_rnw;
   logic              w_req_ready;
   logic              w_rsp_valid;
   logic              w_ceb;
   logic              w_rnw;
   logic              w_oeb;
   logic              w_data_oe;

   assign w_accept = req_valid && r_req_ready;
   assign w_last   = (r_cnt == '0);
   // SETUP is entered on the accept edge, before r_rnw_op holds the new request.
   assign w_op_rnw = w_accept ? req_rnw : r_rnw_op;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_rnw_op    <= 1'b1;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_ceb       <= 1'b1;
         r_rnw       <= 1'b1;
         r_oeb       <= 1'b1;
         r_data_oe   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_req_ready <= w_req_ready;
         r_rsp_valid <= w_rsp_valid;
         r_ceb       <= w_ceb;
         r_rnw       <= w_rnw;
         r_oeb       <= w_oeb;
         r_data_oe   <= w_data_oe;
         if (w_accept) begin
            r_rnw_op <= req_rnw;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
         end
         if (r_state == ST_READ && w_last) begin
            r_rdata <= ram_data_i;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_last ? '0 : r_cnt - 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_SETUP;
               w_cnt_nxt   = cnt_load(SETUP);
            end
         end
         ST_SETUP: begin
            if (w_last) begin
               w_state_nxt = r_rnw_op ? ST_READ : ST_WRITE;
               w_cnt_nxt   = r_rnw_op ? cnt_load(RD_WAIT) : cnt_load(WR_PULSE);
            end
         end
         ST_READ: begin
            if (w_last) begin
               w_state_nxt = ST_RECOVER;
            end
         end
         ST_WRITE: begin
            if (w_last) begin
               w_state_nxt = ST_HOLD;
               w_cnt_nxt   = cnt_load(HOLD);
            end
         end
         ST_HOLD: begin
            if (w_last) begin
               w_state_nxt = ST_RECOVER;
            end
         end
         ST_RECOVER: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Decoded from the next state so the registered strobes line up with r_state.
   always_comb begin
      w_req_ready = 1'b0;
      w_rsp_valid = 1'b0;
      w_ceb       = 1'b1;
      w_rnw       = 1'b1;
      w_oeb       = 1'b1;
      w_data_oe   = 1'b0;
      case (w_state_nxt)
         ST_IDLE: begin
            w_req_ready = 1'b1;
         end
         ST_SETUP: begin
            w_ceb = 1'b0;
            if (w_op_rnw) begin
               w_oeb = 1'b0;
            end else begin
               w_data_oe = 1'b1;
            end
         end
         ST_READ: begin
            w_ceb = 1'b0;
            w_oeb = 1'b0;
         end
         ST_WRITE: begin
            w_ceb     = 1'b0;
            w_rnw     = 1'b0;
            w_data_oe = 1'b1;
         end
         ST_HOLD: begin
            w_ceb     = 1'b0;
            w_data_oe = 1'b1;
         end
         ST_RECOVER: begin
            w_rsp_valid = 1'b1;
         end
         default: begin
            w_req_ready = 1'b0;
         end
      endcase
   end

   assign req_ready   = r_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rdata;
   assign ram_addr    = r_addr;
   assign ram_ceb     = r_ceb;
   assign ram_rnw     = r_rnw;
   assign ram_oeb     = r_oeb;
   assign ram_data_o  = r_wdata;
   assign ram_data_oe = r_data_oe;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_sram_if_m.sv
// Bench for sram_if_m: a default-timing and a swept-timing instance, each on its own SRAM model,
// checked against a byte-array reference and latency formulas taken from the access timing rules.
module tb_sram_if_m;
  import sram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT signals (index 0 = defaults, 1 = sweep) ----------------
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_rnw   [2];
  logic [18:0] req_addr  [2];
  logic [7:0]  req_wdata [2];
  logic        rsp_valid [2];
  logic [7:0]  rsp_rdata [2];
  logic [18:0] ram_addr  [2];
  logic        ram_ceb   [2];
  logic        ram_rnw   [2];
  logic        ram_oeb   [2];
  logic [7:0]  ram_data_o[2];
  logic        ram_data_oe[2];
  state_e      dbg_state [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int P_SET = (k == 0) ? 1 : 2;
    localparam int P_RDW = (k == 0) ? 2 : 4;
    localparam int P_WRP = (k == 0) ? 2 : 3;
    localparam int P_HLD = (k == 0) ? 1 : 2;

    logic [7:0] mem [0:(1<<19)-1];
    logic [7:0] pad_in;
    int rsp_cnt    = 0;
    int conflict   = 0;
    int both_rise  = 0;
    logic prev_ceb = 1'b1;
    logic prev_rnw = 1'b1;

    sram_if_m #(.SETUP(P_SET), .RD_WAIT(P_RDW), .WR_PULSE(P_WRP), .HOLD(P_HLD)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[k]),
      .req_ready  (req_ready[k]),
      .req_rnw    (req_rnw[k]),
      .req_addr   (req_addr[k]),
      .req_wdata  (req_wdata[k]),
      .rsp_valid  (rsp_valid[k]),
      .rsp_rdata  (rsp_rdata[k]),
      .ram_addr   (ram_addr[k]),
      .ram_ceb    (ram_ceb[k]),
      .ram_rnw    (ram_rnw[k]),
      .ram_oeb    (ram_oeb[k]),
      .ram_data_o (ram_data_o[k]),
      .ram_data_oe(ram_data_oe[k]),
      .ram_data_i (pad_in),
      .dbg_state  (dbg_state[k])
    );

    // asynchronous SRAM: reads while CE and OE are low, writes on the rising write strobe
    assign pad_in = (!ram_ceb[k] && !ram_oeb[k]) ? mem[ram_addr[k]] : 8'hEE;
    always @(posedge ram_rnw[k]) begin
      if (!ram_ceb[k] && ram_data_oe[k]) mem[ram_addr[k]] = ram_data_o[k];
    end

    always @(posedge clk) begin
      if (rsp_valid[k]) rsp_cnt++;
    end

    always @(negedge clk) begin
      if (!ram_oeb[k] && ram_data_oe[k]) conflict++;
      if (!rst && !prev_ceb && ram_ceb[k] && !prev_rnw && ram_rnw[k]) both_rise++;
      prev_ceb = ram_ceb[k];
      prev_rnw = ram_rnw[k];
    end
  end

  function automatic int get_rsp(input int k);
    return (k == 0) ? g_dut[0].rsp_cnt : g_dut[1].rsp_cnt;
  endfunction
  function automatic int get_conflict(input int k);
    return (k == 0) ? g_dut[0].conflict : g_dut[1].conflict;
  endfunction
  function automatic int get_both_rise(input int k);
    return (k == 0) ? g_dut[0].both_rise : g_dut[1].both_rise;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [int];
  int exp_rsp [2];
  int acc_cyc [2];

  function automatic int key_of(input int k, input logic [18:0] a);
    return (k << 20) | int'(a);
  endfunction
  // read: response after SETUP+RD_WAIT edges; write: after SETUP+WR_PULSE+HOLD edges
  function automatic int lat_of(input int k, input bit rnw);
    if (k == 0) return rnw ? (1 + 2) : (1 + 2 + 1);
    return rnw ? (2 + 4) : (2 + 3 + 2);
  endfunction
  function automatic int wr_pulse_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge where rsp_valid is seen.
  task automatic access(input int k, input bit rnw, input logic [18:0] a,
                        input logic [7:0] d, input bit keep);
    int n;
    int e;
    int low;
    logic prev_rnw;
    req_valid[k] = 1'b1;
    req_rnw[k]   = rnw;
    req_addr[k]  = a;
    req_wdata[k] = d;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      req_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc_cyc[k] = cyc;
    if (!keep) req_valid[k] = 1'b0;
    e = 0;
    low = 0;
    prev_rnw = 1'b1;
    while (!rsp_valid[k] && e < 100) begin
      if (!ram_rnw[k]) low++;
      if (!prev_rnw && ram_rnw[k]) check_eq("ceb_low_at_rnw_rise", 32'(ram_ceb[k]), 32'd0);
      prev_rnw = ram_rnw[k];
      @(negedge clk);
      e++;
    end
    check_eq(rnw ? "rd_latency" : "wr_latency", e, lat_of(k, rnw));
    check_eq("recover_strobes", {ram_ceb[k], ram_rnw[k], ram_oeb[k], ram_data_oe[k]}, 4'b1110);
    if (rnw) begin
      check_eq("rdata", rsp_rdata[k], ref_mem[key_of(k, a)]);
    end else begin
      check_eq("wr_pulse_len", low, wr_pulse_of(k));
      ref_mem[key_of(k, a)] = d;
    end
    exp_rsp[k]++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a_w;
    logic [18:0] addrs[$];
    logic [18:0] ra;
    logic [7:0]  rd;
    int n;

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_rnw[k]   = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      exp_rsp[k]   = 0;
      acc_cyc[k]   = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: reset values
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_req_ready", 32'(req_ready[k]), 32'd1);
      check_eq("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      check_eq("rst_rsp_rdata", rsp_rdata[k], 32'h00);
      check_eq("rst_ram_addr", ram_addr[k], 32'h0);
      check_eq("rst_strobes", {ram_ceb[k], ram_rnw[k], ram_oeb[k], ram_data_oe[k]}, 4'b1110);
      check_eq("rst_data_o", ram_data_o[k], 32'h00);
      check_eq("rst_state", dbg_state[k], ST_IDLE);
    end
    @(posedge clk);
    #1;
    check_eq("ready_first_edge", 32'(req_ready[0]), 32'd1);
    @(negedge clk);

    // 2: write then read
    access(0, 1'b0, 19'h12345, 8'hA5, 1'b0);
    access(0, 1'b1, 19'h12345, 8'h00, 1'b0);

    // 3: back-to-back with req_valid held high
    access(0, 1'b0, 19'h00001, 8'h3C, 1'b1);
    a_w = acc_cyc[0];
    access(0, 1'b1, 19'h00001, 8'h00, 1'b0);
    check_eq("b2b_accept_gap", acc_cyc[0] - a_w, lat_of(0, 1'b0) + 2);

    // 4: address extremes
    access(0, 1'b0, 19'h00000, 8'h00, 1'b0);
    access(0, 1'b0, 19'h7FFFF, 8'hFF, 1'b0);
    access(0, 1'b1, 19'h00000, 8'h00, 1'b0);
    access(0, 1'b1, 19'h7FFFF, 8'h00, 1'b0);

    // 5: reset during the write pulse
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_rnw[0]   = 1'b0;
    req_addr[0]  = 19'h00020;
    req_wdata[0] = 8'hC3;
    n = 0;
    while (!req_ready[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("abort_in_write", 32'(ram_rnw[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_strobes", {ram_ceb[0], ram_rnw[0], ram_oeb[0], ram_data_oe[0]}, 4'b1110);
    check_eq("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_state", dbg_state[0], ST_IDLE);
    @(negedge clk);
    access(0, 1'b0, 19'h00010, 8'h5A, 1'b0);
    access(0, 1'b1, 19'h00010, 8'h00, 1'b0);

    // 6: parameter sweep instance
    @(negedge clk);
    access(1, 1'b0, 19'h00ABC, 8'h77, 1'b0);
    access(1, 1'b1, 19'h00ABC, 8'h00, 1'b0);

    // randomized traffic on both instances
    for (int k = 0; k < 2; k++) begin
      addrs.delete();
      for (int i = 0; i < 40; i++) begin
        if (addrs.size() != 0 && $urandom_range(0, 1) == 1) begin
          ra = addrs[$urandom_range(0, addrs.size() - 1)];
          access(k, 1'b1, ra, 8'h00, 1'b0);
        end else begin
          ra = 19'($urandom_range(0, 19'h7FFFF));
          rd = 8'($urandom_range(0, 255));
          access(k, 1'b0, ra, rd, 1'b0);
          addrs.push_back(ra);
        end
      end
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq("rsp_count", get_rsp(k), exp_rsp[k]);
      check_eq("oe_bus_conflict", get_conflict(k), 32'd0);
      check_eq("ceb_rnw_same_edge", get_both_rise(k), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
